// File: rtl/matrix_pkg.sv
// Shared constants, types and segment decode for the LED-matrix readback decoder.
package matrix_pkg;

   localparam int unsigned ROWS     = 8;
   localparam int unsigned COLS     = 4;
   localparam int unsigned COL_W    = 2;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned NUM_SEGS = 8;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // frame[c][r] is 1 when row r of column c is lit
   typedef logic [COLS-1:0][ROWS-1:0] frame_t;

   // Cell masks, written column 3 down to column 0
   localparam frame_t MASK_A  = {8'h00, 8'h01, 8'h01, 8'h00};
   localparam frame_t MASK_B  = {8'h06, 8'h00, 8'h00, 8'h00};
   localparam frame_t MASK_C  = {8'h30, 8'h00, 8'h00, 8'h00};
   localparam frame_t MASK_D  = {8'h00, 8'h40, 8'h40, 8'h00};
   localparam frame_t MASK_E  = {8'h00, 8'h00, 8'h00, 8'h30};
   localparam frame_t MASK_F  = {8'h00, 8'h00, 8'h00, 8'h06};
   localparam frame_t MASK_G  = {8'h00, 8'h08, 8'h08, 8'h00};
   localparam frame_t MASK_DP = {8'h80, 8'h00, 8'h00, 8'h00};

   localparam frame_t SEG_MASK [NUM_SEGS] = '{MASK_A, MASK_B, MASK_C, MASK_D,
                                              MASK_E, MASK_F, MASK_G, MASK_DP};

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // Returns {consistency_error, active-high segments}
   function automatic logic [NUM_SEGS:0] decode_frame(input frame_t f);
      logic [NUM_SEGS-1:0] segs;
      logic                err;
      frame_t              hit;
      frame_t              used;
      segs = '0;
      err  = 1'b0;
      used = '0;
      for (int unsigned s = 0; s < NUM_SEGS; s++) begin
         hit  = f & SEG_MASK[s];
         used = used | SEG_MASK[s];
         if (hit == SEG_MASK[s]) begin
            segs[s] = 1'b1;
         end else if (hit != '0) begin
            err = 1'b1;
         end
      end
      if ((f & ~used) != '0) begin
         err = 1'b1;
      end
      return {err, segs};
   endfunction

endpackage

// File: rtl/matrix_col_tracker.sv
// Column strobe decode, change detection against the last legal column, and settle counter.
module matrix_col_tracker
   import matrix_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [COLS-1:0]  col_n,
   input  logic             cnt_clr,
   input  logic             cnt_inc,
   output logic [COL_W-1:0] col_idx_c,
   output logic             col_blank_c,
   output logic             col_illegal_c,
   output logic             col_change_c,
   output logic [COL_W-1:0] prev_col,
   output logic             settle_hit_c
);

   logic [COL_W-1:0] prev_col_q, prev_col_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             col_legal;

   always_comb begin
      col_idx_c     = '0;
      col_blank_c   = 1'b0;
      col_illegal_c = 1'b0;
      case (col_n)
         4'b1110: col_idx_c = 2'd0;
         4'b1101: col_idx_c = 2'd1;
         4'b1011: col_idx_c = 2'd2;
         4'b0111: col_idx_c = 2'd3;
         4'b1111: col_blank_c = 1'b1;
         default: col_illegal_c = 1'b1;
      endcase
   end

   assign col_legal    = !col_blank_c && !col_illegal_c;
   assign col_change_c = col_legal && (col_idx_c != prev_col_q);
   assign settle_hit_c = cnt_inc && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
   assign prev_col     = prev_col_q;

   always_comb begin
      prev_col_d = prev_col_q;
      cnt_d      = cnt_q;
      if (col_legal) begin
         prev_col_d = col_idx_c;
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (cnt_inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_col_q <= '0;
         cnt_q      <= '0;
      end else begin
         prev_col_q <= prev_col_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: rtl/matrix_to_sevenseg.sv
// Reassembles a strobed 8x4 matrix frame and decodes it back to an active-low segment byte.
// Define MATRIX_DECODE_SYNC_EN to add 2-flop synchronizers on io_out/io_col.
module matrix_to_sevenseg
   import matrix_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] io_out,
   input  logic [3:0] io_col,
   output logic [7:0] sevenseg_out,
   output logic       valid,
   output logic       frame_err
);

   logic [ROWS-1:0] rows_n;
   logic [COLS-1:0] cols_n;

`ifdef MATRIX_DECODE_SYNC_EN
   logic [ROWS-1:0] row_meta_q, row_sync_q;
   logic [COLS-1:0] col_meta_q, col_sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         row_meta_q <= '1;
         row_sync_q <= '1;
         col_meta_q <= '1;
         col_sync_q <= '1;
      end else begin
         row_meta_q <= io_out;
         row_sync_q <= row_meta_q;
         col_meta_q <= io_col;
         col_sync_q <= col_meta_q;
      end
   end

   assign rows_n = row_sync_q;
   assign cols_n = col_sync_q;
`else
   assign rows_n = io_out;
   assign cols_n = io_col;
`endif

   logic [COL_W-1:0] col_idx_c, prev_col;
   logic             col_blank_c, col_illegal_c, col_change_c, settle_hit_c;
   logic             cnt_clr, cnt_inc;

   matrix_col_tracker #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_tracker (
      .clk          (clk),
      .reset        (reset),
      .col_n        (cols_n),
      .cnt_clr      (cnt_clr),
      .cnt_inc      (cnt_inc),
      .col_idx_c    (col_idx_c),
      .col_blank_c  (col_blank_c),
      .col_illegal_c(col_illegal_c),
      .col_change_c (col_change_c),
      .prev_col     (prev_col),
      .settle_hit_c (settle_hit_c)
   );

   state_t              state_q, state_d;
   frame_t              frame_q, frame_d;
   logic [COLS-1:0]     seen_q, seen_d;
   logic [7:0]          seg_q, seg_d;
   logic                valid_q, valid_d;
   logic                ferr_q, ferr_d;
   logic [NUM_SEGS:0]   dec;
   logic                seq_err, start_frame;

   assign dec = decode_frame(frame_q);

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      seen_d      = seen_q;
      seg_d       = seg_q;
      valid_d     = 1'b0;
      ferr_d      = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      seq_err     = 1'b0;
      start_frame = 1'b0;
      case (state_q)
         SYNC: begin
            if (!col_blank_c && !col_illegal_c && (col_idx_c == '0)) begin
               start_frame = 1'b1;
            end
         end
         SETTLE: begin
            // The column must stay put until its rows are sampled
            if (col_illegal_c || col_blank_c || col_change_c) begin
               seq_err = 1'b1;
            end else begin
               cnt_inc = 1'b1;
               if (settle_hit_c) begin
                  frame_d[col_idx_c] = ~rows_n;
                  seen_d[col_idx_c]  = 1'b1;
                  state_d            = HOLD;
               end
            end
         end
         HOLD: begin
            if (col_illegal_c) begin
               seq_err = 1'b1;
            end else if (col_change_c) begin
               if (col_idx_c != COL_W'(prev_col + COL_W'(1))) begin
                  seq_err = 1'b1;
               end else if (prev_col == COL_W'(COLS - 1)) begin
                  if (seen_q != '1) begin
                     seq_err = 1'b1;
                  end else begin
                     if (dec[NUM_SEGS]) begin
                        ferr_d = 1'b1;
                     end else begin
                        valid_d = 1'b1;
                        seg_d   = ~dec[NUM_SEGS-1:0];
                     end
                     start_frame = 1'b1;
                  end
               end else begin
                  state_d = SETTLE;
                  cnt_clr = 1'b1;
               end
            end
         end
         default: state_d = SYNC;
      endcase
      if (start_frame) begin
         state_d = SETTLE;
         cnt_clr = 1'b1;
         frame_d = '0;
         seen_d  = '0;
      end
      if (seq_err) begin
         ferr_d  = 1'b1;
         frame_d = '0;
         seen_d  = '0;
         state_d = SYNC;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SYNC;
         frame_q <= '0;
         seen_q  <= '0;
         seg_q   <= 8'hFF;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         seen_q  <= seen_d;
         seg_q   <= seg_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign sevenseg_out = seg_q;
   assign valid        = valid_q;
   assign frame_err    = ferr_q;

endmodule

// File: tb/tb_matrix_to_sevenseg.sv
// Self-checking bench for matrix_to_sevenseg: directed loopback cases plus randomized frames vs a reference model.
module tb_matrix_to_sevenseg;

   localparam int S = 4;
`ifdef MATRIX_DECODE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] io_out;
   logic [3:0] io_col;
   logic [7:0] sevenseg_out;
   logic       valid;
   logic       frame_err;

   always #5 clk = ~clk;

   matrix_to_sevenseg #(.SETTLE_CYCLES(S)) dut (
      .clk         (clk),
      .reset       (reset),
      .io_out      (io_out),
      .io_col      (io_col),
      .sevenseg_out(sevenseg_out),
      .valid       (valid),
      .frame_err   (frame_err)
   );

   // Segment cell list: (row, col) pairs, segments a..g, dp
   int seg_r [8][2] = '{'{0,0}, '{1,2}, '{4,5}, '{6,6}, '{4,5}, '{1,2}, '{3,3}, '{7,7}};
   int seg_c [8][2] = '{'{1,2}, '{3,3}, '{3,3}, '{1,2}, '{0,0}, '{0,0}, '{1,2}, '{3,3}};
   int seg_n [8]    = '{2, 2, 2, 2, 2, 2, 2, 1};

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int n_ferr   = 0;
   int cycle    = 0;
   int last_valid = 0;
   int vgap     = 0;

   // Reference model state
   bit       hunting;
   int       cur, run, got;
   bit       sampled;
   bit [7:0] mcells [4];
   bit [7:0] exp_seg;
   bit       exp_valid, exp_err;
   logic [3:0] pc [2];
   logic [7:0] pr [2];

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cycle);
      end
   endtask

   function automatic int col_of(input logic [3:0] p);
      case (p)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         4'b1111: return -1;
         default: return -2;
      endcase
   endfunction

   function automatic logic [3:0] col_pat(input int c);
      logic [3:0] p;
      p    = 4'hF;
      p[c] = 1'b0;
      return p;
   endfunction

   function automatic logic [31:0] seg_cells(input logic [7:0] seg);
      logic [31:0] cells;
      cells = '0;
      for (int s = 0; s < 8; s++)
         if (!seg[s])
            for (int k = 0; k < seg_n[s]; k++) cells[seg_c[s][k]*8 + seg_r[s][k]] = 1'b1;
      return cells;
   endfunction

   // {inconsistent, active-high segments} from the captured cells
   function automatic logic [8:0] model_decode();
      int total, mapped, lit;
      logic [7:0] segs;
      logic bad;
      total = 0; mapped = 0; segs = '0; bad = 1'b0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 8; r++) total += int'(mcells[c][r]);
      for (int s = 0; s < 8; s++) begin
         lit = 0;
         for (int k = 0; k < seg_n[s]; k++) lit += int'(mcells[seg_c[s][k]][seg_r[s][k]]);
         mapped += lit;
         if (lit == seg_n[s]) segs[s] = 1'b1;
         else if (lit > 0) bad = 1'b1;
      end
      if (total != mapped) bad = 1'b1;
      return {bad, segs};
   endfunction

   task automatic new_frame();
      cur = 0; run = 0; sampled = 1'b0; got = 0;
      for (int c = 0; c < 4; c++) mcells[c] = '0;
   endtask

   task automatic model_reset();
      hunting = 1'b1;
      new_frame();
      exp_seg = 8'hFF; exp_valid = 1'b0; exp_err = 1'b0;
      pc[0] = 4'hF; pc[1] = 4'hF; pr[0] = 8'hFF; pr[1] = 8'hFF;
   endtask

   task automatic model_step(input logic [3:0] p, input logic [7:0] rows);
      int c;
      bit seq_err;
      logic [8:0] d;
      c = col_of(p);
      seq_err = 1'b0;
      exp_valid = 1'b0;
      exp_err = 1'b0;
      if (hunting) begin
         if (c == 0) begin
            hunting = 1'b0;
            new_frame();
         end
      end else if (c == -2) begin
         seq_err = 1'b1;
      end else if (!sampled) begin
         if (c != cur) seq_err = 1'b1;
         else begin
            run++;
            if (run == S) begin
               mcells[cur] = ~rows;
               sampled = 1'b1;
               got++;
            end
         end
      end else if (c == -1 || c == cur) begin
         // idle within the column visit
      end else if (c == (cur + 1) % 4) begin
         if (cur == 3) begin
            if (got == 4) begin
               d = model_decode();
               if (d[8]) exp_err = 1'b1;
               else begin
                  exp_valid = 1'b1;
                  exp_seg = ~d[7:0];
               end
               new_frame();
            end else seq_err = 1'b1;
         end else begin
            cur = c; run = 0; sampled = 1'b0;
         end
      end else begin
         seq_err = 1'b1;
      end
      if (seq_err) begin
         exp_err = 1'b1;
         hunting = 1'b1;
      end
   endtask

   task automatic step(input logic rst, input logic [3:0] p, input logic [7:0] rows);
      logic [3:0] mp;
      logic [7:0] mr;
      reset = rst; io_col = p; io_out = rows;
      @(posedge clk);
      if (rst) model_reset();
      else begin
`ifdef MATRIX_DECODE_SYNC_EN
         mp = pc[1]; mr = pr[1];
         pc[1] = pc[0]; pr[1] = pr[0];
         pc[0] = p; pr[0] = rows;
`else
         mp = p; mr = rows;
`endif
         model_step(mp, mr);
      end
      #1;
      cycle++;
      check("outs", {22'd0, sevenseg_out, valid, frame_err}, {22'd0, exp_seg, exp_valid, exp_err});
      if (valid) begin
         n_valid++;
         vgap = cycle - last_valid;
         last_valid = cycle;
      end
      if (frame_err) n_ferr++;
   endtask

   task automatic col_run(input int c, input int n, input logic [31:0] cells);
      for (int i = 0; i < n; i++) step(1'b0, col_pat(c), ~cells[c*8 +: 8]);
   endtask

   task automatic send_cells(input logic [31:0] cells, input int per_col, input int gap);
      for (int c = 0; c < 4; c++) begin
         col_run(c, per_col, cells);
         for (int g = 0; g < gap; g++) step(1'b0, 4'hF, 8'($urandom));
      end
   endtask

   task automatic send_frame(input logic [7:0] seg, input int per_col, input int gap);
      send_cells(seg_cells(seg), per_col, gap);
   endtask

   task automatic tail(input int n);
      for (int i = 0; i < n; i++) step(1'b0, col_pat(0), 8'hFF);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 4'hF, 8'hFF);
   endtask

   initial begin
      int v0, e0, kind, per, gap, bc, len;
      logic [7:0]  seg, r;
      logic [31:0] cells;
      logic [3:0]  p;
      logic        rst;

      model_reset();
      reset = 1'b1; io_col = 4'hF; io_out = 8'hFF;

      // Reset values
      do_reset(3);
      check("rst_seg", {24'd0, sevenseg_out}, 32'hFF);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);

      // Digit "1"
      v0 = n_valid; e0 = n_ferr;
      send_frame(8'hF9, 16, 0);
      send_frame(8'hF9, 16, 0);
      tail(8);
      check("one_valid_cnt", n_valid - v0, 2);
      check("one_err_cnt", n_ferr - e0, 0);
      check("one_seg", {24'd0, sevenseg_out}, 32'hF9);

      // "8." with steady once-per-64-cycle valids
      do_reset(2);
      v0 = n_valid; e0 = n_ferr;
      for (int i = 0; i < 4; i++) send_frame(8'h00, 16, 0);
      tail(8);
      check("eight_valid_cnt", n_valid - v0, 4);
      check("eight_err_cnt", n_ferr - e0, 0);
      check("eight_seg", {24'd0, sevenseg_out}, 32'h00);
      check("eight_gap", vgap, 64);

      // Column order 0,1,3
      do_reset(2);
      v0 = n_valid; e0 = n_ferr;
      cells = seg_cells(8'hF9);
      col_run(0, 16, cells); col_run(1, 16, cells); col_run(3, 16, cells);
      check("skip_err_cnt", n_ferr - e0, 1);
      check("skip_no_valid", n_valid - v0, 0);
      send_frame(8'hF9, 16, 0);
      tail(8);
      check("skip_recover_valid", n_valid - v0, 1);

      // Illegal pattern mid-frame
      do_reset(2);
      v0 = n_valid; e0 = n_ferr;
      col_run(0, 16, cells); col_run(1, 16, cells);
      step(1'b0, 4'b1100, 8'hFF); step(1'b0, 4'b1100, 8'hFF);
      col_run(2, 16, cells); col_run(3, 16, cells);
      check("illegal_err_cnt", n_ferr - e0, 1);
      send_frame(8'hF9, 16, 0);
      tail(8);
      check("illegal_recover_valid", n_valid - v0, 1);

      // Blank gaps between columns are harmless
      do_reset(2);
      v0 = n_valid; e0 = n_ferr;
      send_frame(8'hA4, 16, 3);
      send_frame(8'hA4, 16, 3);
      tail(8);
      check("gap_err_cnt", n_ferr - e0, 0);
      check("gap_valid_cnt", n_valid - v0, 2);
      check("gap_seg", {24'd0, sevenseg_out}, 32'hA4);

      // Lit cell outside the map, then a partially lit segment
      do_reset(2);
      v0 = n_valid; e0 = n_ferr;
      send_frame(8'hA4, 16, 0);
      send_cells(seg_cells(8'hA4) | (32'd1 << 9), 16, 0);
      tail(8);
      check("outside_valid_cnt", n_valid - v0, 1);
      check("outside_err_cnt", n_ferr - e0, 1);
      check("outside_seg", {24'd0, sevenseg_out}, 32'hA4);
      send_cells(32'd1 << 8, 16, 0);
      tail(8);
      check("partial_err_cnt", n_ferr - e0, 2);
      check("partial_seg", {24'd0, sevenseg_out}, 32'hA4);

      // Reset during column 2
      do_reset(2);
      v0 = n_valid; e0 = n_ferr;
      cells = seg_cells(8'h92);
      col_run(0, 16, cells); col_run(1, 16, cells); col_run(2, 8, cells);
      step(1'b1, col_pat(2), ~cells[23:16]);
      check("midrst_seg", {24'd0, sevenseg_out}, 32'hFF);
      check("midrst_valid", {31'd0, valid}, 32'd0);
      check("midrst_err", {31'd0, frame_err}, 32'd0);
      col_run(2, 8, cells); col_run(3, 16, cells);
      send_frame(8'h92, 16, 0);
      check("midrst_no_partial_valid", n_valid - v0, 0);
      tail(8);
      check("midrst_valid_cnt", n_valid - v0, 1);
      check("midrst_err_cnt", n_ferr - e0, 0);
      check("midrst_seg_after", {24'd0, sevenseg_out}, 32'h92);

      // Randomized frames with occasional corruption
      do_reset(2);
      v0 = n_valid;
      for (int f = 0; f < 120; f++) begin
         seg   = 8'($urandom);
         cells = seg_cells(seg);
         kind  = $urandom_range(0, 9);
         per   = $urandom_range(S + 3, 20);
         gap   = $urandom_range(0, 2);
         bc    = $urandom_range(0, 3);
         if (kind == 1) cells = cells ^ (32'd1 << $urandom_range(0, 31));
         for (int c = 0; c < 4; c++) begin
            if (kind == 2 && c == bc) continue;
            len = (kind == 3 && c == bc) ? $urandom_range(1, S) : per;
            for (int i = 0; i < len; i++) begin
               p   = col_pat(c);
               r   = ~cells[c*8 +: 8];
               rst = 1'b0;
               if (kind == 0 && c == bc && i == len / 2) begin
                  p = 4'($urandom);
                  while (col_of(p) != -2) p = 4'($urandom);
               end
               if (kind == 5 && $urandom_range(0, 1) == 1) r = 8'($urandom);
               if (kind == 4 && c == bc && i == len / 2) rst = 1'b1;
               step(rst, p, r);
            end
            for (int g = 0; g < gap; g++) step(1'b0, 4'hF, 8'($urandom));
         end
      end
      tail(8);
      check("rand_valid_seen", {31'd0, (n_valid - v0) > 0}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
